calcu_secuencial: RTL and testbench

Registered, parametrised N-bit calculator: next generation of the team's combinational calculator. Executes the same ten operations behind a start/ready/valid handshake with registered result and flags. Add/sub/mul/logic/shift finish in one cycle; division and modulo use an iterative restoring divider. Sits between the operand/selection front-end and the display/result register path.

---
 rtl/calcu_pkg.sv | 30 +++
 rtl/divisor_restaurador.sv | 73 +++++++
 rtl/calcu_secuencial.sv | 183 ++++++++++++++++++
 tb/tb_calcu_secuencial.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calcu_pkg.sv
// calcu_pkg: shared definitions for the sequential calculator.
//   opcode_t : operation codes carried on 'seleccion' (10..15 are illegal)
//   FLAG_*   : bit positions inside the 4-bit flags word {N, Z, C, V}
//   estado_t : controller states (IDLE accepts requests, DIVIDE runs the divider)
package calcu_pkg;

  typedef enum logic [3:0] {
    OP_SUMA   = 4'd0,
    OP_RESTA  = 4'd1,
    OP_MULT   = 4'd2,
    OP_MOD    = 4'd3,
    OP_DIV    = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_XOR    = 4'd7,
    OP_LSHIFT = 4'd8,
    OP_RSHIFT = 4'd9
  } opcode_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_DIVIDE = 1'b1
  } estado_t;

endpackage

// File: rtl/divisor_restaurador.sv
// divisor_restaurador: N-bit unsigned iterative restoring divider, one
// quotient bit per clock.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_inicio     : load operands and start (divisor must be non-zero)
//   i_dividendo  : dividend
//   i_divisor    : divisor
//   o_fin        : high during the cycle in which the last iteration runs
//   o_cociente   : quotient, valid while o_fin is high
//   o_resto      : remainder, valid while o_fin is high
// The outputs are the combinational result of the current iteration, so the
// caller can register the final answer on the same edge that completes the
// N-th step (no extra cycle after the last iteration).
module divisor_restaurador #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inicio,
  input  logic [N-1:0] i_dividendo,
  input  logic [N-1:0] i_divisor,
  output logic         o_fin,
  output logic [N-1:0] o_cociente,
  output logic [N-1:0] o_resto
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]  r_resto;
  logic [N-1:0]  r_cociente;
  logic [N-1:0]  r_divisor;
  logic [CW-1:0] r_cuenta;
  logic          r_activo;

  logic [N:0]    w_parcial;
  logic [N:0]    w_diferencia;
  logic          w_cabe;
  logic [N-1:0]  w_resto_sig;
  logic [N-1:0]  w_cociente_sig;

  // Shift the next dividend bit into the partial remainder and try to
  // subtract; a non-negative difference means the quotient bit is 1.
  assign w_parcial      = {r_resto, r_cociente[N-1]};
  assign w_diferencia   = w_parcial - {1'b0, r_divisor};
  assign w_cabe         = ~w_diferencia[N];
  assign w_resto_sig    = w_cabe ? w_diferencia[N-1:0] : w_parcial[N-1:0];
  assign w_cociente_sig = {r_cociente[N-2:0], w_cabe};

  assign o_fin      = r_activo && (r_cuenta == CW'(N-1));
  assign o_cociente = w_cociente_sig;
  assign o_resto    = w_resto_sig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resto    <= '0;
      r_cociente <= '0;
      r_divisor  <= '0;
      r_cuenta   <= '0;
      r_activo   <= 1'b0;
    end else if (i_inicio) begin
      r_resto    <= '0;
      r_cociente <= i_dividendo;
      r_divisor  <= i_divisor;
      r_cuenta   <= '0;
      r_activo   <= 1'b1;
    end else if (r_activo) begin
      r_resto    <= w_resto_sig;
      r_cociente <= w_cociente_sig;
      r_cuenta   <= r_cuenta + CW'(1);
      if (o_fin) r_activo <= 1'b0;
    end
  end

endmodule

// File: rtl/calcu_secuencial.sv
// calcu_secuencial: registered N-bit calculator with a start/ready/valid
// handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   inicio     : request; accepted on a rising edge where listo=1
//   a, b       : operands, captured on accept
//   seleccion  : opcode (see calcu_pkg::opcode_t), captured on accept
//   listo      : block can accept a request this cycle
//   valido     : one-cycle pulse, salida/flags were updated by the last edge
//   salida     : result, held until the next result
//   flags      : {N, Z, C, V}, held with salida
//   estado     : controller state, for observation only
// Handshake: a request is taken exactly when inicio && listo at a rising edge;
// every taken request yields exactly one valido pulse, in request order.
// Build option: define CALCU_DIV_EN to include the iterative divider for
// opcodes 3/4; without it those opcodes finish in one cycle as salida=0, Z, V.
module calcu_secuencial
  import calcu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   seleccion,
  output logic         listo,
  output logic         valido,
  output logic [N-1:0] salida,
  output logic [3:0]   flags,
  output estado_t      estado
);

  localparam logic [N:0] LIM = (N+1)'(N);

  estado_t        r_estado;
  estado_t        w_estado_sig;

  logic [N:0]     w_suma;
  logic [N-1:0]   w_resta;
  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] w_izq;
  logic [2*N-1:0] w_der;
  logic [N:0]     w_b_ext;
  logic [N-1:0]   w_res;
  logic           w_c;
  logic           w_v;
  logic           w_a_divide;
  logic [3:0]     w_flags;
  logic           w_acepta;
  logic           w_div_fin;

  assign w_suma  = {1'b0, a} + {1'b0, b};
  assign w_resta = a - b;
  assign w_prod  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  // Double-width shifts: the bit just beyond the result is the last bit out.
  assign w_izq   = {{N{1'b0}}, a} << b;
  assign w_der   = {a, {N{1'b0}}} >> b;
  assign w_b_ext = {1'b0, b};

  assign listo    = rst_n && (r_estado == ST_IDLE);
  assign w_acepta = inicio && listo;
  assign estado   = r_estado;

  // Single-cycle datapath; w_a_divide marks requests that need the divider.
  always_comb begin
    w_res      = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    w_a_divide = 1'b0;
    case (seleccion)
      OP_SUMA: begin
        w_res = w_suma[N-1:0];
        w_c   = w_suma[N];
        w_v   = (a[N-1] == b[N-1]) && (w_suma[N-1] != a[N-1]);
      end
      OP_RESTA: begin
        w_res = w_resta;
        w_c   = (a < b);
        w_v   = (a[N-1] != b[N-1]) && (w_resta[N-1] != a[N-1]);
      end
      OP_MULT: begin
        w_res = w_prod[N-1:0];
        w_c   = |w_prod[2*N-1:N];
      end
      OP_MOD, OP_DIV: begin
`ifdef CALCU_DIV_EN
        if (b == '0) begin
          w_v   = 1'b1;
          w_res = (seleccion == OP_DIV) ? '1 : a;
        end else begin
          w_a_divide = 1'b1;
        end
`else
        w_v = 1'b1;
`endif
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_LSHIFT: begin
        if (w_b_ext < LIM) begin
          w_res = w_izq[N-1:0];
          w_c   = w_izq[N];
        end else if (w_b_ext == LIM) begin
          w_c = a[N-1];
        end
      end
      OP_RSHIFT: begin
        if (w_b_ext < LIM) begin
          w_res = w_der[2*N-1:N];
          w_c   = w_der[N-1];
        end else if (w_b_ext == LIM) begin
          w_c = a[0];
        end
      end
      default: ;
    endcase
  end

  assign w_flags = {w_res[N-1], (w_res == '0), w_c, w_v};

`ifdef CALCU_DIV_EN
  logic         r_es_mod;
  logic [N-1:0] w_cociente;
  logic [N-1:0] w_resto;
  logic [N-1:0] w_div_res;

  divisor_restaurador #(.N(N)) u_divisor (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inicio    (w_acepta && w_a_divide),
    .i_dividendo (a),
    .i_divisor   (b),
    .o_fin       (w_div_fin),
    .o_cociente  (w_cociente),
    .o_resto     (w_resto)
  );

  assign w_div_res = r_es_mod ? w_resto : w_cociente;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_es_mod <= 1'b0;
    else if (w_acepta) r_es_mod <= (seleccion == OP_MOD);
  end
`else
  assign w_div_fin = 1'b0;
`endif

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      ST_IDLE:   if (w_acepta && w_a_divide) w_estado_sig = ST_DIVIDE;
      ST_DIVIDE: if (w_div_fin) w_estado_sig = ST_IDLE;
      default:   w_estado_sig = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado <= ST_IDLE;
      salida   <= '0;
      flags    <= '0;
      valido   <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      valido   <= 1'b0;
      if (w_acepta && !w_a_divide) begin
        salida <= w_res;
        flags  <= w_flags;
        valido <= 1'b1;
      end
`ifdef CALCU_DIV_EN
      else if ((r_estado == ST_DIVIDE) && w_div_fin) begin
        salida <= w_div_res;
        flags  <= {w_div_res[N-1], (w_div_res == '0), 1'b0, 1'b0};
        valido <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_calcu_secuencial.sv
// tb_calcu_secuencial: table-driven bench for calcu_secuencial (N=4).
// Expected {salida, flags} words are queued when a request is accepted and
// compared by a monitor whenever valido pulses. Works with or without
// CALCU_DIV_EN; division expectations switch on the same macro.
module tb_calcu_secuencial;
  import calcu_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inicio = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [3:0]   seleccion = '0;
  logic         listo;
  logic         valido;
  logic [N-1:0] salida;
  logic [3:0]   flags;
  estado_t      estado;

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sal;
    logic [3:0]   fl;
  } vec_t;

  logic [N+3:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pushed = 0;
  int n_valido = 0;
  int run = 0;
  int max_run = 0;

  calcu_secuencial #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inicio    (inicio),
    .a         (a),
    .b         (b),
    .seleccion (seleccion),
    .listo     (listo),
    .valido    (valido),
    .salida    (salida),
    .flags     (flags),
    .estado    (estado)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [N+3:0] e;
    if (valido === 1'b1) begin
      n_valido++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected valido: salida=%0h flags=%0h", salida, flags);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("result #%0d {salida,flags}", n_valido), {24'd0, salida, flags}, {24'd0, e});
      end
    end else begin
      run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Holds the request until listo is seen, then lets one edge accept it.
  task automatic send(input logic [3:0] op, input logic [N-1:0] aa, input logic [N-1:0] bb,
                      input logic [N-1:0] sal, input logic [3:0] fl);
    int t;
    seleccion = op;
    a = aa;
    b = bb;
    inicio = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (listo) break;
      t++;
      if (t > 50) break;
    end
    if (!listo) begin
      n_cmp++;
      n_err++;
      $display("FAIL listo timeout: op=%0d", op);
      inicio = 1'b0;
    end else begin
      exp_q.push_back({sal, fl});
      n_pushed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    inicio = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  vec_t bt[8];
  vec_t tv[22];
  vec_t dv[6];

  initial begin
    int lo;
    int t;
    int dlat;

    bt[0] = '{OP_SUMA,   3, 2,  5, 4'b0000};
    bt[1] = '{OP_RESTA,  3, 2,  1, 4'b0000};
    bt[2] = '{OP_MULT,   3, 2,  6, 4'b0000};
    bt[3] = '{OP_AND,    3, 2,  2, 4'b0000};
    bt[4] = '{OP_OR,     3, 2,  3, 4'b0000};
    bt[5] = '{OP_XOR,    3, 2,  1, 4'b0000};
    bt[6] = '{OP_LSHIFT, 3, 2, 12, 4'b1000};
    bt[7] = '{OP_RSHIFT, 3, 2,  0, 4'b0110};

    tv[0]  = '{OP_SUMA,    7,  1,  8, 4'b1001};
    tv[1]  = '{OP_SUMA,   15,  1,  0, 4'b0110};
    tv[2]  = '{OP_RESTA,   2,  5, 13, 4'b1010};
    tv[3]  = '{OP_RESTA,   8,  1,  7, 4'b0001};
    tv[4]  = '{OP_MULT,    5,  4,  4, 4'b0010};
    tv[5]  = '{OP_MULT,    0,  9,  0, 4'b0100};
    tv[6]  = '{OP_AND,    12, 10,  8, 4'b1000};
    tv[7]  = '{OP_OR,      0,  0,  0, 4'b0100};
    tv[8]  = '{OP_XOR,    15, 15,  0, 4'b0100};
    tv[9]  = '{OP_LSHIFT,  9,  4,  0, 4'b0110};
    tv[10] = '{OP_LSHIFT,  9,  5,  0, 4'b0100};
    tv[11] = '{OP_LSHIFT,  9,  0,  9, 4'b1000};
    tv[12] = '{OP_LSHIFT,  9,  1,  2, 4'b0010};
    tv[13] = '{OP_RSHIFT,  9,  4,  0, 4'b0110};
    tv[14] = '{OP_RSHIFT,  9,  1,  4, 4'b0010};
    tv[15] = '{OP_RSHIFT,  8, 15,  0, 4'b0100};
    tv[16] = '{4'd10,      5,  3,  0, 4'b0100};
    tv[17] = '{4'd15,      5,  3,  0, 4'b0100};
`ifdef CALCU_DIV_EN
    tv[18] = '{OP_DIV,     9,  0, 15, 4'b1001};
    tv[19] = '{OP_MOD,     9,  0,  9, 4'b1001};
    tv[20] = '{OP_MOD,     0,  0,  0, 4'b0101};
    tv[21] = '{OP_DIV,     0,  0, 15, 4'b1001};
`else
    tv[18] = '{OP_DIV,     9,  0,  0, 4'b0101};
    tv[19] = '{OP_MOD,     9,  0,  0, 4'b0101};
    tv[20] = '{OP_MOD,     0,  0,  0, 4'b0101};
    tv[21] = '{OP_DIV,     0,  0,  0, 4'b0101};
`endif

`ifdef CALCU_DIV_EN
    dlat = N;
    dv[0] = '{OP_DIV, 13,  4,  3, 4'b0000};
    dv[1] = '{OP_MOD, 13,  4,  1, 4'b0000};
    dv[2] = '{OP_DIV, 15,  1, 15, 4'b1000};
    dv[3] = '{OP_MOD, 15,  4,  3, 4'b0000};
    dv[4] = '{OP_DIV,  4, 13,  0, 4'b0100};
    dv[5] = '{OP_MOD,  4, 13,  4, 4'b0000};
`else
    dlat = 0;
    dv[0] = '{OP_DIV, 13,  4,  0, 4'b0101};
    dv[1] = '{OP_MOD, 13,  4,  0, 4'b0101};
    dv[2] = '{OP_DIV, 15,  1,  0, 4'b0101};
    dv[3] = '{OP_MOD, 15,  4,  0, 4'b0101};
    dv[4] = '{OP_DIV,  4, 13,  0, 4'b0101};
    dv[5] = '{OP_MOD,  4, 13,  0, 4'b0101};
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset salida", salida, 0);
    chk("reset flags", flags, 0);
    chk("reset valido", valido, 0);
    chk("reset listo", listo, 0);
    rst_n = 1'b1;
    #1;
    chk("listo after release", listo, 1);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops with inicio held.
    max_run = 0;
    for (int i = 0; i < 8; i++) send(bt[i].op, bt[i].a, bt[i].b, bt[i].sal, bt[i].fl);
    idle(3);
    chk("back-to-back valido run", max_run, 8);

    // Arithmetic flags, shift boundaries, illegal codes, divide by zero.
    for (int i = 0; i < 22; i++) send(tv[i].op, tv[i].a, tv[i].b, tv[i].sal, tv[i].fl);
    idle(3);

    // Division/modulo latency: listo low for the iteration count, then
    // valido with listo already high.
    for (int i = 0; i < 6; i++) begin
      send(dv[i].op, dv[i].a, dv[i].b, dv[i].sal, dv[i].fl);
      inicio = 1'b0;
      lo = 0;
      t = 0;
      forever begin
        @(negedge clk);
        if (t == 0 && dlat > 0) chk("estado during divide", estado, ST_DIVIDE);
        if (valido) break;
        if (!listo) lo++;
        t++;
        if (t > 20) break;
      end
      chk($sformatf("div %0d listo-low cycles", i), lo, dlat);
      chk($sformatf("div %0d valido seen", i), valido, 1);
      chk($sformatf("div %0d listo with valido", i), listo, 1);
      idle(1);
    end

    // Reset while busy: the pending result is dropped and outputs clear.
`ifdef CALCU_DIV_EN
    send(OP_DIV, 13, 4, 3, 4'b0000);
    inicio = 1'b0;
    repeat (2) @(negedge clk);
    void'(exp_q.pop_back());
    n_pushed--;
`else
    send(OP_SUMA, 7, 1, 8, 4'b1001);
    inicio = 1'b0;
    @(negedge clk);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort salida", salida, 0);
    chk("abort flags", flags, 0);
    chk("abort valido", valido, 0);
    chk("abort listo", listo, 0);
    rst_n = 1'b1;
    #1;
    chk("abort listo after release", listo, 1);
    chk("abort estado", estado, ST_IDLE);
    idle(N + 4);

    // One more request after the abort to show the block recovered.
    send(OP_XOR, 10, 5, 15, 4'b1000);
    idle(2);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    chk("valido count", n_valido, n_pushed);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
